// File: rtl/shift_reg_pkg.sv
// Types and defaults shared by the shift-register blocks (piso_serializer, sipo).
package shift_reg_pkg;

    localparam int unsigned SR_WIDTH_DEFAULT = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel-load and serial-stream handshake bundle for piso_serializer.
interface piso_serializer_if
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = SR_WIDTH_DEFAULT
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             serial_out;
    logic             serial_valid;
    logic             serial_ready;
    logic             serial_last;
    logic             busy;

    modport master (
        output in_valid, in_data, serial_ready,
        input  in_ready, serial_out, serial_valid, serial_last, busy
    );

    modport slave (
        input  in_valid, in_data, serial_ready,
        output in_ready, serial_out, serial_valid, serial_last, busy
    );
endinterface

// File: rtl/sipo.sv
// Serial-in parallel-out receive register; shifts {q[W-2:0], serial_in} when enabled.
module sipo
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = SR_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] parallel_out
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parallel_out <= '0;
        end else if (shift_en) begin
            parallel_out <= {parallel_out[WIDTH-2:0], serial_in};
        end
    end
endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shift register with valid/ready on both sides;
// a word on the last-bit transfer can be loaded back-to-back with no idle cycle.
module piso_serializer
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH     = SR_WIDTH_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    piso_serializer_if.slave      bus
);
    localparam int unsigned     CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    piso_state_t      state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             last;
    logic             xfer;
    logic             load;

    assign last = (state == SHIFT) && (cnt == CNT_LAST);
    assign xfer = (state == SHIFT) && bus.serial_ready;
    assign load = bus.in_valid && bus.in_ready;

    assign bus.in_ready     = (state == IDLE) || (last && bus.serial_ready);
    assign bus.serial_out   = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    assign bus.serial_valid = (state == SHIFT);
    assign bus.busy         = (state == SHIFT);
    assign bus.serial_last  = last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A load on the final transfer overrides the shift/idle decision.
    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        if (xfer) begin
            sr_nxt = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
            if (last) begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
        if (load) begin
            sr_nxt    = bus.in_data;
            cnt_nxt   = '0;
            state_nxt = SHIFT;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: piso_serializer (MSB and LSB first) with sipo loopback.
module tb_piso_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    piso_serializer_if #(.WIDTH(4)) bus0 ();
    piso_serializer_if #(.WIDTH(4)) bus1 ();

    logic [3:0] sipo_out;
    logic       sipo_en;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign sipo_en = bus0.serial_valid && bus0.serial_ready;
    sipo #(.WIDTH(4)) rx (.clk(clk), .rst(rst), .shift_en(sipo_en),
                          .serial_in(bus0.serial_out), .parallel_out(sipo_out));

    logic [1:0] q0[$];
    logic [1:0] q1[$];
    logic [1:0] e0, e1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // seq lists the bits in emission order, leftmost first.
    task automatic expect_bits(input int sel, input logic [3:0] seq);
        for (int i = 3; i >= 0; i--) begin
            if (sel == 0) q0.push_back({seq[i], i == 0});
            else          q1.push_back({seq[i], i == 0});
        end
    endtask

    // Returns #1 after the load edge, i.e. during the first bit cycle.
    task automatic load(input int sel, input logic [3:0] w);
        bit ok;
        ok = 1'b0;
        if (sel == 0) begin bus0.in_valid = 1'b1; bus0.in_data = w; end
        else          begin bus1.in_valid = 1'b1; bus1.in_data = w; end
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = (sel == 0) ? bus0.in_ready : bus1.in_ready;
            @(posedge clk); #1;
        end
        if (sel == 0) begin bus0.in_valid = 1'b0; bus0.in_data = 4'h0; end
        else          begin bus1.in_valid = 1'b0; bus1.in_data = 4'h0; end
        chk("load_accepted", {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            idle = !bus0.busy && !bus1.busy;
        end
        chk("idle_within_budget", {31'b0, idle}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && bus0.serial_valid && bus0.serial_ready) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL msb_unexpected_bit: got bit %0b, expected no transfer", bus0.serial_out);
            end else begin
                e0 = q0.pop_front();
                chk("msb_serial_out", {31'b0, bus0.serial_out}, {31'b0, e0[1]});
                chk("msb_serial_last", {31'b0, bus0.serial_last}, {31'b0, e0[0]});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus1.serial_valid && bus1.serial_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL lsb_unexpected_bit: got bit %0b, expected no transfer", bus1.serial_out);
            end else begin
                e1 = q1.pop_front();
                chk("lsb_serial_out", {31'b0, bus1.serial_out}, {31'b0, e1[1]});
                chk("lsb_serial_last", {31'b0, bus1.serial_last}, {31'b0, e1[0]});
            end
        end
    end

    initial begin
        bus0.in_valid = 1'b0; bus0.in_data = 4'h0; bus0.serial_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_data = 4'h0; bus1.serial_ready = 1'b1;

        // Reset for two cycles
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, bus0.in_ready}, 32'd1);
        chk("rst_serial_valid", {31'b0, bus0.serial_valid}, 32'd0);
        chk("rst_serial_out", {31'b0, bus0.serial_out}, 32'd0);
        chk("rst_busy", {31'b0, bus0.busy}, 32'd0);
        chk("rst_serial_last", {31'b0, bus0.serial_last}, 32'd0);
        @(posedge clk); #1;

        // Single word, MSB first, with sipo loopback
        expect_bits(0, 4'b1011);
        load(0, 4'b1011);
        bus0.in_data = 4'b0100;
        wait_idle();
        chk("sipo_1011", {28'b0, sipo_out}, 32'hB);

        // Back-to-back words with in_valid held high
        @(posedge clk); #1;
        expect_bits(0, 4'b1100);
        expect_bits(0, 4'b0110);
        bus0.in_valid = 1'b1; bus0.in_data = 4'b1100;
        @(posedge clk); #1;
        bus0.in_data = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("b2b_in_ready", {31'b0, bus0.in_ready}, (i == 3 || i == 7) ? 32'd1 : 32'd0);
            chk("b2b_serial_valid", {31'b0, bus0.serial_valid}, 32'd1);
            if (i == 3) begin
                @(posedge clk); #1;
                bus0.in_valid = 1'b0;
            end
        end
        wait_idle();
        chk("sipo_0110", {28'b0, sipo_out}, 32'h6);

        // Stall for three cycles after the first bit
        @(posedge clk); #1;
        expect_bits(0, 4'b1001);
        load(0, 4'b1001);
        @(posedge clk); #1;
        bus0.serial_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_serial_out", {31'b0, bus0.serial_out}, 32'd0);
            chk("stall_serial_valid", {31'b0, bus0.serial_valid}, 32'd1);
            chk("stall_serial_last", {31'b0, bus0.serial_last}, 32'd0);
            chk("stall_in_ready", {31'b0, bus0.in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        bus0.serial_ready = 1'b1;
        wait_idle();
        chk("sipo_1001", {28'b0, sipo_out}, 32'h9);

        // LSB first
        @(posedge clk); #1;
        expect_bits(1, 4'b1101);
        load(1, 4'b1011);
        wait_idle();

        // Reset in the middle of a word
        @(posedge clk); #1;
        expect_bits(0, 4'b1111);
        load(0, 4'b1111);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_bits_left", q0.size(), 32'd2);
        q0.delete();
        chk("midrst_serial_out", {31'b0, bus0.serial_out}, 32'd0);
        chk("midrst_serial_valid", {31'b0, bus0.serial_valid}, 32'd0);
        chk("midrst_serial_last", {31'b0, bus0.serial_last}, 32'd0);
        chk("midrst_busy", {31'b0, bus0.busy}, 32'd0);
        chk("midrst_in_ready", {31'b0, bus0.in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        expect_bits(0, 4'b0001);
        load(0, 4'b0001);
        wait_idle();
        chk("sipo_0001", {28'b0, sipo_out}, 32'h1);

        chk("msb_queue_drained", q0.size(), 32'd0);
        chk("lsb_queue_drained", q1.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out shift register with valid/ready handshakes on both sides. It is the transmit-side counterpart of the `sipo` receive register. A WIDTH-bit word accepted on the parallel port is emitted one bit per transfer on `serial_out`, MSB first by default. Feeding that stream into `sipo` (same WIDTH, shifting `{q[W-2:0], serial_in}`) reconstructs the original word.

## Interface
- `WIDTH`, 4: word width in bits; legal range ≥ 2.
- `MSB_FIRST`, 1: 1 emits bit WIDTH-1 first; 0 emits bit 0 first.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset; one clock, asynchronous, active-high.
- `in_valid`  input  1  parallel word available.
- `in_ready`  output  1  block can accept a word this cycle.
- `in_data`  input  WIDTH  parallel word; sampled only on the `in_valid && in_ready` edge.
- `serial_out`  output  1  current serial bit.
- `serial_valid`  output  1  `serial_out` holds a valid bit.
- `serial_ready`  input  1  consumer accepts the bit this cycle.
- `serial_last`  output  1  current bit is the final bit of the word.
- `busy`  output  1  a word is in flight (state SHIFT).

## Operation
- States: IDLE and SHIFT. Reset enters IDLE.
- Load: a load occurs on an edge where `in_valid && in_ready`.
  - `in_data` is captured into the shift register.
  - The bit counter is cleared.
  - State goes to SHIFT.
- Bit transfer: a transfer occurs on an edge in SHIFT where `serial_ready` is high.
  - The shift register moves one position: left when MSB_FIRST=1, right when 0.
  - The counter increments.
- `serial_out` is the shift register's MSB when MSB_FIRST=1, otherwise its LSB. It is combinational from the register.
- `serial_valid` = (state == SHIFT).
- `busy` = (state == SHIFT).
- `serial_last` = SHIFT && counter == WIDTH-1.
- Word completion: on the transfer where `serial_last` is high:
  - If a load also occurs on that edge, stay in SHIFT with the new word (back-to-back).
  - Otherwise go to IDLE.
- `in_ready` = IDLE || (serial_last && serial_ready). This is combinational from state, counter and `serial_ready`. No other combinational input-to-output path exists.
- Stall: while `serial_ready` is low, the register, counter, `serial_out` and `serial_last` hold, and `serial_valid` stays high.
- `in_data` changes outside a load have no effect.
- `in_valid` held high in IDLE: loaded on the next edge.

## Timing
- Reset values: state IDLE, shift register 0, counter 0. Hence `serial_out`=0, `serial_valid`=0, `serial_last`=0, `busy`=0, `in_ready`=1.
- Latency: load at edge T puts the first bit on `serial_out` with `serial_valid`=1 during cycle T+1.
- With `serial_ready` tied high, the word occupies exactly WIDTH cycles, T+1 .. T+WIDTH.
- Back-to-back streaming with `serial_ready` high gives 100 % utilisation: no idle cycle between words.
- Reset asserted mid-word: the word is dropped and all outputs take their reset values immediately (asynchronous). The first load after reset deassertion starts a fresh word at bit 0.
- Counter width is $clog2(WIDTH). It never exceeds WIDTH-1, so it does not wrap inside a word.

## Structure
- Shared package `shift_reg_pkg` holds:
  - the state enum `piso_state_t` (IDLE, SHIFT);
  - the default WIDTH constant `SR_WIDTH_DEFAULT` = 4, shared with `sipo`.
- No sub-module is needed: one FSM, one counter and one shift register form a single module.
- The bench instantiates `piso_serializer` driving `sipo` for the loopback check.

## Test plan
- Reset held 2 cycles, then released with `in_valid`=0 → `in_ready`=1, `serial_valid`=0, `serial_out`=0, `busy`=0.
- Load 4'b1011, `serial_ready`=1 → `serial_out` = 1,0,1,1 on cycles T+1..T+4. `serial_last` is high only on T+4. `sipo` `parallel_out` = 4'b1011 after the 4th shift.
- Two words 4'b1100 then 4'b0110 with `in_valid` held high → 8 consecutive valid bits 1,1,0,0,0,1,1,0. `in_ready` pulses high only on the last-bit cycle.
- Load 4'b1001 and drop `serial_ready` for 3 cycles after bit 1 → `serial_out` holds 0 with `serial_valid`=1 during the stall. The sequence resumes 0,0,1 with no lost or duplicated bits.
- MSB_FIRST=0, load 4'b1011 → `serial_out` = 1,1,0,1.
- Assert `rst` after bit 2 of word 4'b1111 → outputs are at reset values in the same cycle. A subsequent load of 4'b0001 emits 0,0,0,1.
